// File: rtl/mp_addsub.sv
// Word-serial multi-precision adder/subtractor: one WIDTH-bit ripple limb per cycle,
// least significant limb first, carry held in a register between limbs.
module mp_addsub #(
    parameter int N     = 256,
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int LIMBS = N / WIDTH;
    localparam int CW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt;

    logic [WIDTH-1:0] limb_sum;
    logic             limb_cout;
    logic             rc;
    logic [N-1:0]     sum_next;

    // Limb adder: plain ripple CPA over the low limb of the operand registers.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        limb_sum = '0;
        rc       = carry_reg;
        for (int i = 0; i < WIDTH; i++) begin
            limb_sum[i] = a_reg[i] ^ b_reg[i] ^ rc;
            rc          = (a_reg[i] & b_reg[i]) | (rc & (a_reg[i] ^ b_reg[i]));
        end
        limb_cout = rc;
    end

    // Result fills from the top, so after LIMBS shifts limb 0 lands at bit 0.
    always_comb begin
        sum_next                = sum >> WIDTH;
        sum_next[N-1 -: WIDTH]  = limb_sum;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction as x + ~y + 1: invert y, seed the carry with sub.
                        a_reg     <= x;
                        b_reg     <= y ^ {N{sub}};
                        carry_reg <= sub;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> WIDTH;
                    b_reg     <= b_reg >> WIDTH;
                    sum       <= sum_next;
                    carry_reg <= limb_cout;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= limb_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
